aes_round_sched: RTL and testbench

//  Round sequencer for the iterative AES-128 encryption core. Drives the shared 4-S-box

---
 rtl/aes_ctrl_pkg.sv | 39 +++
 rtl/aes_round_sched_if.sv | 37 +++
 rtl/aes_rcon_gen.sv | 41 ++++
 rtl/aes_round_sched.sv | 157 +++++++++++++++
 tb/tb_aes_round_sched.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package   : aes_ctrl_pkg
// Purpose   : State encoding, round-constant values and the xtime helper
//             shared by the AES-128 round sequencer and its RCON generator.
// Revision  : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] LOAD      = 3'd1;
   localparam logic [2:0] SUB_ISSUE = 3'd2;
   localparam logic [2:0] SUB_WAIT  = 3'd3;
   localparam logic [2:0] SHIFT     = 3'd4;
   localparam logic [2:0] MIX       = 3'd5;
   localparam logic [2:0] ARK       = 3'd6;
   localparam logic [2:0] DONE      = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE      = IDLE,
      S_LOAD      = LOAD,
      S_SUB_ISSUE = SUB_ISSUE,
      S_SUB_WAIT  = SUB_WAIT,
      S_SHIFT     = SHIFT,
      S_MIX       = MIX,
      S_ARK       = ARK,
      S_DONE      = DONE
   } state_t;

   localparam logic [7:0] RCON_INIT  = 8'h01;
   localparam logic [7:0] AES_REDUCE = 8'h1B;

   // Multiply by x in GF(2^8) modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_REDUCE : 8'h00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_sched_if.sv
`default_nettype none
// ============================================================================
// Interface : aes_round_sched_if
// Purpose   : Start/done handshake, SubByte engine handshake and datapath
//             enables between the AES round sequencer and its neighbours.
// Revision  : 1.0 - initial release
// ============================================================================
interface aes_round_sched_if;
   logic       start;
   logic       sb_done;
   logic       key_done;
   logic       ready;
   logic       ld_input;
   logic       sb_start;
   logic       sr_en;
   logic       mc_en;
   logic       ark_en;
   logic [3:0] round;
   logic [7:0] rcon;
   logic       done;
   logic       err;

   // Sequencer side.
   modport slave (
      input  start, sb_done, key_done,
      output ready, ld_input, sb_start, sr_en, mc_en, ark_en,
             round, rcon, done, err
   );

   // Controller / datapath side.
   modport master (
      output start, sb_done, key_done,
      input  ready, ld_input, sb_start, sr_en, mc_en, ark_en,
             round, rcon, done, err
   );
endinterface
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// ============================================================================
// Module    : aes_rcon_gen
// Purpose   : 8-bit round-constant register. load_i restarts at 01, step_i
//             advances by xtime; otherwise the value is held.
// Revision  : 1.0 - initial release
// ============================================================================
module aes_rcon_gen
   import aes_ctrl_pkg::*;
(
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       load_i,
   input  wire logic       step_i,
   output logic [7:0]      rcon_o
);

   logic [7:0] rcon_q;
   logic [7:0] rcon_d;

   // Next value: load has priority over step.
   always_comb begin
      rcon_d = rcon_q;
      if (load_i)
         rcon_d = RCON_INIT;
      else if (step_i)
         rcon_d = xtime(rcon_q);
   end

   // Round-constant register, resets to the first constant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rcon_q <= RCON_INIT;
      else
         rcon_q <= rcon_d;
   end

   assign rcon_o = rcon_q;

endmodule
`default_nettype wire

// File: rtl/aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module    : aes_round_sched
// Purpose   : Round sequencer for the iterative AES-128 core. Issues the shared
//             SubByte/SubWord engine, then ShiftRows, MixColumns, AddRoundKey
//             once per round; tracks round index, RCON and a wait timeout.
// Revision  : 1.0 - initial release
// ============================================================================
module aes_round_sched
   import aes_ctrl_pkg::*;
#(
   parameter int NR      = 10,
   parameter int TIMEOUT = 15
)
(
   input  wire logic          clk,
   input  wire logic          rst,
   aes_round_sched_if.slave   bus
);

   state_t     state_q,    state_d;
   logic [3:0] round_q,    round_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       sb_seen_q,  sb_seen_d;
   logic       key_seen_q, key_seen_d;
   logic       err_q,      err_d;

   logic       rcon_load;
   logic       rcon_step;
   logic       sb_any;
   logic       key_any;
   logic       ready_o, ld_input_o, sb_start_o, sr_en_o, mc_en_o, ark_en_o, done_o;

   // Handshake pulses count in the cycle they arrive, not only once latched.
   assign sb_any  = sb_seen_q  | bus.sb_done;
   assign key_any = key_seen_q | bus.key_done;

   // Next-state, bookkeeping and Moore outputs.
   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      wait_cnt_d = wait_cnt_q;
      sb_seen_d  = sb_seen_q;
      key_seen_d = key_seen_q;
      err_d      = err_q;
      rcon_load  = 1'b0;
      rcon_step  = 1'b0;
      ready_o    = 1'b0;
      ld_input_o = 1'b0;
      sb_start_o = 1'b0;
      sr_en_o    = 1'b0;
      mc_en_o    = 1'b0;
      ark_en_o   = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (bus.start) begin
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // Load plaintext/key and apply the initial whitening key.
            ld_input_o = 1'b1;
            ark_en_o   = 1'b1;
            round_d    = 4'd1;
            rcon_load  = 1'b1;
            state_d    = S_SUB_ISSUE;
         end
         S_SUB_ISSUE: begin
            sb_start_o = 1'b1;
            sb_seen_d  = 1'b0;
            key_seen_d = 1'b0;
            wait_cnt_d = 8'd0;
            state_d    = S_SUB_WAIT;
         end
         S_SUB_WAIT: begin
            sb_seen_d  = sb_any;
            key_seen_d = key_any;
            if (sb_any && key_any) begin
               state_d = S_SHIFT;
            end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
               // Engine hung: abandon the block without a done pulse.
               err_d   = 1'b1;
               round_d = 4'd0;
               state_d = S_IDLE;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         S_SHIFT: begin
            sr_en_o = 1'b1;
            state_d = (round_q < 4'(NR)) ? S_MIX : S_ARK;
         end
         S_MIX: begin
            mc_en_o = 1'b1;
            state_d = S_ARK;
         end
         S_ARK: begin
            ark_en_o = 1'b1;
            if (round_q == 4'(NR)) begin
               round_d = 4'd0;
               state_d = S_DONE;
            end else begin
               round_d   = round_q + 4'd1;
               rcon_step = 1'b1;
               state_d   = S_SUB_ISSUE;
            end
         end
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         round_q    <= 4'd0;
         wait_cnt_q <= 8'd0;
         sb_seen_q  <= 1'b0;
         key_seen_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         round_q    <= round_d;
         wait_cnt_q <= wait_cnt_d;
         sb_seen_q  <= sb_seen_d;
         key_seen_q <= key_seen_d;
         err_q      <= err_d;
      end
   end

   aes_rcon_gen u_rcon_gen (
      .clk    (clk),
      .rst    (rst),
      .load_i (rcon_load),
      .step_i (rcon_step),
      .rcon_o (bus.rcon)
   );

   assign bus.ready    = ready_o;
   assign bus.ld_input = ld_input_o;
   assign bus.sb_start = sb_start_o;
   assign bus.sr_en    = sr_en_o;
   assign bus.mc_en    = mc_en_o;
   assign bus.ark_en   = ark_en_o;
   assign bus.done     = done_o;
   assign bus.round    = round_q;
   assign bus.err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
`default_nettype none
// ============================================================================
// Module    : tb_aes_round_sched
// Purpose   : Directed self-checking bench for the AES round sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_aes_round_sched;

   logic clk = 1'b0;
   logic rst = 1'b1;

   aes_round_sched_if bus();

   aes_round_sched #(.NR(10), .TIMEOUT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_vec = 0;
   int         n_err = 0;

   int         sb_dly  [1:16];
   int         key_dly [1:16];
   int         issue_cnt, mc_cnt, ark_cnt, done_cyc, err_cyc;
   int         issue_cyc [1:16];
   int         shift_cyc [1:16];
   logic [7:0] rcon_at   [1:16];
   logic [3:0] round_at  [1:16];
   logic       ready_next;
   logic       err_at_load;
   logic [7:0] exp_rcon  [1:10];

   task automatic set_delays(input int k);
      for (int i = 1; i <= 16; i++) begin
         sb_dly[i]  = k;
         key_dly[i] = k;
      end
   endtask

   // One encryption: start pulse in cycle 0, responder answers each sb_start.
   task automatic run_op(input int busy_cyc, input int stop_cyc);
      int c;
      int sb_due;
      int key_due;
      issue_cnt = 0; mc_cnt = 0; ark_cnt = 0;
      done_cyc = -1; err_cyc = -1; sb_due = -1; key_due = -1;
      ready_next = 1'b0; err_at_load = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         issue_cyc[i] = -1; shift_cyc[i] = -1; rcon_at[i] = 8'h00; round_at[i] = 4'd0;
      end
      @(negedge clk);
      bus.start = 1'b1;
      c = 0;
      while (c < 400) begin
         @(negedge clk);
         c++;
         bus.start    = (c == busy_cyc);
         bus.sb_done  = 1'b0;
         bus.key_done = 1'b0;
         if (c == 1) err_at_load = bus.err;
         if (c == stop_cyc) return;
         if (bus.sb_start) begin
            issue_cnt++;
            if (issue_cnt <= 16) begin
               issue_cyc[issue_cnt] = c;
               rcon_at[issue_cnt]   = bus.rcon;
               round_at[issue_cnt]  = bus.round;
               sb_due  = (sb_dly[issue_cnt]  > 0) ? c + sb_dly[issue_cnt]  : -1;
               key_due = (key_dly[issue_cnt] > 0) ? c + key_dly[issue_cnt] : -1;
            end
         end
         if (bus.sr_en && issue_cnt >= 1 && issue_cnt <= 16) shift_cyc[issue_cnt] = c;
         if (bus.mc_en)  mc_cnt++;
         if (bus.ark_en) ark_cnt++;
         if (c == sb_due)  bus.sb_done  = 1'b1;
         if (c == key_due) bus.key_done = 1'b1;
         if (bus.done) begin
            done_cyc = c;
            @(negedge clk);
            bus.start  = 1'b0;
            ready_next = bus.ready;
            return;
         end
         if (bus.err) begin
            err_cyc    = c;
            ready_next = bus.ready;
            return;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] en;
      repeat (2) @(negedge clk);
      en = {bus.ld_input, bus.sb_start, bus.sr_en, bus.mc_en, bus.ark_en, bus.done};
      n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.ready); end
      n_vec++; if (bus.round !== 4'd0) begin n_err++; $display("FAIL reset_round got %0d want 0", bus.round); end
      n_vec++; if (bus.rcon !== 8'h01) begin n_err++; $display("FAIL reset_rcon got %h want 01", bus.rcon); end
      n_vec++; if (bus.err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus.err); end
      n_vec++; if (en !== 6'b0) begin n_err++; $display("FAIL reset_enables got %b want 000000", en); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_op();
      set_delays(6);
      run_op(-1, -1);
      n_vec++; if (issue_cnt !== 10) begin n_err++; $display("FAIL full_sb_start_count got %0d want 10", issue_cnt); end
      n_vec++; if (mc_cnt !== 9) begin n_err++; $display("FAIL full_mc_count got %0d want 9", mc_cnt); end
      n_vec++; if (ark_cnt !== 11) begin n_err++; $display("FAIL full_ark_count got %0d want 11", ark_cnt); end
      n_vec++; if (done_cyc !== 101) begin n_err++; $display("FAIL full_done_cycle got %0d want 101", done_cyc); end
      n_vec++; if (ready_next !== 1'b1) begin n_err++; $display("FAIL full_ready_after got %b want 1", ready_next); end
   endtask

   task automatic test_rcon_seq();
      for (int i = 1; i <= 10; i++) begin
         n_vec++;
         if (rcon_at[i] !== exp_rcon[i]) begin
            n_err++; $display("FAIL rcon_round%0d got %h want %h", i, rcon_at[i], exp_rcon[i]);
         end
         n_vec++;
         if (round_at[i] !== 4'(i)) begin
            n_err++; $display("FAIL round_index%0d got %0d want %0d", i, round_at[i], i);
         end
      end
   endtask

   task automatic test_handshake_order();
      set_delays(6);
      key_dly[2] = 4;
      sb_dly[4]  = 5;
      key_dly[4] = 5;
      run_op(-1, -1);
      n_vec++; if (shift_cyc[2] - issue_cyc[2] !== 7) begin n_err++; $display("FAIL order_key_first_shift got %0d want 7", shift_cyc[2] - issue_cyc[2]); end
      n_vec++; if (shift_cyc[4] - issue_cyc[4] !== 6) begin n_err++; $display("FAIL order_joint_shift got %0d want 6", shift_cyc[4] - issue_cyc[4]); end
      n_vec++; if (done_cyc !== 100) begin n_err++; $display("FAIL order_done_cycle got %0d want 100", done_cyc); end
   endtask

   task automatic test_timeout();
      set_delays(6);
      sb_dly[3] = 0;
      run_op(-1, -1);
      n_vec++; if (err_cyc !== 38) begin n_err++; $display("FAIL timeout_err_cycle got %0d want 38", err_cyc); end
      n_vec++; if (done_cyc !== -1) begin n_err++; $display("FAIL timeout_no_done got %0d want -1", done_cyc); end
      n_vec++; if (ready_next !== 1'b1) begin n_err++; $display("FAIL timeout_ready got %b want 1", ready_next); end
      n_vec++; if (issue_cnt !== 3) begin n_err++; $display("FAIL timeout_issue_count got %0d want 3", issue_cnt); end
      repeat (3) @(negedge clk);
      n_vec++; if (bus.err !== 1'b1) begin n_err++; $display("FAIL timeout_err_sticky got %b want 1", bus.err); end
      set_delays(6);
      run_op(-1, -1);
      n_vec++; if (err_at_load !== 1'b0) begin n_err++; $display("FAIL timeout_err_cleared got %b want 0", err_at_load); end
      n_vec++; if (done_cyc !== 101) begin n_err++; $display("FAIL timeout_recover_done got %0d want 101", done_cyc); end
   endtask

   task automatic test_start_busy();
      set_delays(6);
      run_op(42, -1);
      n_vec++; if (done_cyc !== 101) begin n_err++; $display("FAIL busy_done_cycle got %0d want 101", done_cyc); end
      n_vec++; if (issue_cnt !== 10) begin n_err++; $display("FAIL busy_issue_count got %0d want 10", issue_cnt); end
      n_vec++; if (rcon_at[10] !== 8'h36) begin n_err++; $display("FAIL busy_last_rcon got %h want 36", rcon_at[10]); end
   endtask

   task automatic test_reset_mid();
      logic [5:0] en;
      set_delays(6);
      run_op(-1, 64);
      rst = 1'b1;
      #1;
      en = {bus.ld_input, bus.sb_start, bus.sr_en, bus.mc_en, bus.ark_en, bus.done};
      n_vec++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", bus.ready); end
      n_vec++; if (bus.round !== 4'd0) begin n_err++; $display("FAIL midrst_round got %0d want 0", bus.round); end
      n_vec++; if (bus.rcon !== 8'h01) begin n_err++; $display("FAIL midrst_rcon got %h want 01", bus.rcon); end
      n_vec++; if (en !== 6'b0) begin n_err++; $display("FAIL midrst_enables got %b want 000000", en); end
      @(negedge clk);
      rst = 1'b0;
      run_op(-1, -1);
      n_vec++; if (done_cyc !== 101) begin n_err++; $display("FAIL midrst_done_cycle got %0d want 101", done_cyc); end
      for (int i = 1; i <= 10; i++) begin
         n_vec++;
         if (rcon_at[i] !== exp_rcon[i]) begin
            n_err++; $display("FAIL midrst_rcon_round%0d got %h want %h", i, rcon_at[i], exp_rcon[i]);
         end
      end
   endtask

   initial begin
      bus.start    = 1'b0;
      bus.sb_done  = 1'b0;
      bus.key_done = 1'b0;
      exp_rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
      test_reset();
      test_full_op();
      test_rcon_seq();
      test_handshake_order();
      test_timeout();
      test_start_busy();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
